board_run_ctrl: RTL

BOARD_RUN_CTRL -- requirements
Module: board_run_ctrl

---
 rtl/board_run_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/board_run_ctrl.sv
// board_run_ctrl: board-level CPU run controller.
// Generates a CPU clock enable from a run mode (full / slow / single-step / halt),
// counts enabled cycles, drives a heartbeat and an LED window onto debug channels.
// Optional feature macro: STEP_DEBOUNCE_EN selects a debounced step key
// (IDLE/PRESS_WAIT/PRESSED/RELEASE_WAIT FSM); when undefined, every falling
// edge of the synchronized key is a step.
module board_run_ctrl #(
   parameter  int CLK_HZ     = 50_000_000,
   parameter  int SLOW_HZ    = 10,
   parameter  int DEB_CYCLES = 1_000_000,
   parameter  int NCH        = 4,
   parameter  int DW         = 32,
   parameter  int LED_W      = 8,
   localparam int DIV        = CLK_HZ / SLOW_HZ,
   localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1,
   localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int NWIN       = DW / LED_W,
   localparam int WIN_W      = (NWIN > 1) ? $clog2(NWIN) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           mode_i,
   input  logic                 step_key_n_i,
   input  logic [CH_W-1:0]      ch_sel_i,
   input  logic [WIN_W-1:0]     win_sel_i,
   input  logic [NCH*DW-1:0]    ch_data_i,
   output logic                 cpu_ce_o,
   output logic [15:0]          step_cnt_o,
   output logic [LED_W-1:0]     led_o,
   output logic                 heartbeat_o
);

   typedef enum logic [1:0] {
      MODE_FULL = 2'b00,
      MODE_SLOW = 2'b01,
      MODE_STEP = 2'b10,
      MODE_HALT = 2'b11
   } mode_t;

   logic [1:0]       r_mode_meta;
   mode_t            r_mode_s;
   logic             r_key_meta;
   logic             r_key_s;
   logic [DIV_W-1:0] r_div_cnt;
   logic             r_heartbeat;
   logic             r_cpu_ce;
   logic [15:0]      r_step_cnt;
   logic [LED_W-1:0] r_led;
   logic             w_tick;
   logic             w_step_pulse;
   logic             w_ce_next;
   logic [LED_W-1:0] w_led_next;

   // Two-flop synchronizers; reset to "halt" and "key released" so nothing runs out of reset.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode_meta <= 2'b11;
         r_mode_s    <= MODE_HALT;
         r_key_meta  <= 1'b1;
         r_key_s     <= 1'b1;
      end else begin
         r_mode_meta <= mode_i;
         r_mode_s    <= mode_t'(r_mode_meta);
         r_key_meta  <= step_key_n_i;
         r_key_s     <= r_key_meta;
      end
   end

   // Free-running slow-rate divider; runs in every mode so the heartbeat never stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div_cnt   <= '0;
         r_heartbeat <= 1'b0;
      end else begin
         r_div_cnt   <= w_tick ? '0 : r_div_cnt + 1'b1;
         r_heartbeat <= r_heartbeat ^ w_tick;
      end
   end

   assign w_tick = (r_div_cnt == DIV_W'(DIV - 1));

`ifdef STEP_DEBOUNCE_EN
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } deb_state_t;

   deb_state_t       r_deb_state;
   deb_state_t       w_deb_state_next;
   logic [DEB_W-1:0] r_deb_cnt;
   logic [DEB_W-1:0] w_deb_cnt_next;

   // Debounce state and its single shared counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_deb_state <= IDLE;
         r_deb_cnt   <= '0;
      end else begin
         r_deb_state <= w_deb_state_next;
         r_deb_cnt   <= w_deb_cnt_next;
      end
   end

   // Debounce transitions; the step pulse fires only on the PRESS_WAIT -> PRESSED edge.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_deb_state_next = r_deb_state;
      w_deb_cnt_next   = r_deb_cnt;
      w_step_pulse     = 1'b0;
      case (r_deb_state)
         IDLE: begin
            if (!r_key_s) begin
               w_deb_state_next = PRESS_WAIT;
               w_deb_cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (r_key_s) begin
               w_deb_state_next = IDLE;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
               w_deb_state_next = PRESSED;
               w_step_pulse     = 1'b1;
            end else begin
               w_deb_cnt_next = r_deb_cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (r_key_s) begin
               w_deb_state_next = RELEASE_WAIT;
               w_deb_cnt_next   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (!r_key_s) begin
               w_deb_state_next = PRESSED;
            end else if (r_deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
               w_deb_state_next = IDLE;
            end else begin
               w_deb_cnt_next = r_deb_cnt + 1'b1;
            end
         end
         default: w_deb_state_next = IDLE;
      endcase
   end
`else
   logic r_key_prev;

   // Previous synchronized key level for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_key_prev <= 1'b1;
      else        r_key_prev <= r_key_s;
   end

   assign w_step_pulse = r_key_prev & ~r_key_s;
`endif

   // Enable source by synchronized mode; a step pulse outside step mode is simply dropped.
   always_comb begin
      w_ce_next = 1'b0;
      case (r_mode_s)
         MODE_FULL: w_ce_next = 1'b1;
         MODE_SLOW: w_ce_next = w_tick;
         MODE_STEP: w_ce_next = w_step_pulse;
         default:   w_ce_next = 1'b0;
      endcase
   end

   // Registered enable and enabled-cycle counter (wraps naturally at 16 bits).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cpu_ce   <= 1'b0;
         r_step_cnt <= '0;
      end else begin
         r_cpu_ce   <= w_ce_next;
         r_step_cnt <= r_step_cnt + 16'(r_cpu_ce);
      end
   end

   // LED window select; out-of-range channels read as zero.
   always_comb begin
      w_led_next = '0;
      if (32'(ch_sel_i) < 32'(NCH)) begin
         w_led_next = ch_data_i[ch_sel_i * DW + win_sel_i * LED_W +: LED_W];
      end
   end

   // LED window register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_led <= '0;
      else        r_led <= w_led_next;
   end

   assign cpu_ce_o    = r_cpu_ce;
   assign step_cnt_o  = r_step_cnt;
   assign led_o       = r_led;
   assign heartbeat_o = r_heartbeat;

endmodule
